// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM word, RAM handshake state and arbiter state.
// MEM_ARB_MAX_DSTREAK is the default data-streak limit for memory_arbiter.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE,
    IGRANT,
    DGRANT
  } arbstate_t;

  localparam int MEM_ARB_MAX_DSTREAK = 4;

endpackage

// File: rtl/memory_arbiter.sv
// Arbitrates icache/dcache miss ports onto one RAM port, data first.
// Define MEM_ARB_FAIR_EN to bound data streaks while iREN is pending.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int MAX_DSTREAK = MEM_ARB_MAX_DSTREAK
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate
);

  arbstate_t state_q, state_d;
  word_t     ihold_q, ihold_d;
  word_t     dhold_q, dhold_d;
  logic      icomp, dcomp;
  logic      dreq;
  logic      fair_block;

  assign dreq = dREN | dWEN;

`ifdef MEM_ARB_FAIR_EN
  localparam int SW = $clog2(MAX_DSTREAK + 1);

  logic [SW-1:0] streak_q, streak_d;

  assign fair_block = iREN && (streak_q == SW'(MAX_DSTREAK));

  always_comb begin
    streak_d = streak_q;
    if (!iREN || icomp) begin
      streak_d = '0;
    end else if (dcomp && streak_q != SW'(MAX_DSTREAK)) begin
      streak_d = streak_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end
`else
  logic unused_maxd;

  assign fair_block  = 1'b0;
  assign unused_maxd = (MAX_DSTREAK > 0);
`endif

  always_comb begin
    state_d  = state_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = ihold_q;
    dload    = dhold_q;
    icomp    = 1'b0;
    dcomp    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dreq && !fair_block) begin
          state_d = DGRANT;
        end else if (iREN) begin
          state_d = IGRANT;
        end
      end
      IGRANT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        if (!iREN) begin
          state_d = IDLE;
        end else if (ramstate == ACCESS) begin
          icomp   = 1'b1;
          iwait   = 1'b0;
          iload   = ramload;
          state_d = IDLE;
        end else if (ramstate == ERROR) begin
          state_d = IDLE;
        end
      end
      DGRANT: begin
        ramREN   = dREN & ~dWEN;
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (!dreq) begin
          state_d = IDLE;
        end else if (ramstate == ACCESS) begin
          dcomp   = 1'b1;
          dwait   = 1'b0;
          dload   = ramload;
          state_d = IDLE;
        end else if (ramstate == ERROR) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // icache writes its line the cycle after iwait drops, so hold the word
  assign ihold_d = icomp ? ramload : ihold_q;
  assign dhold_d = dcomp ? ramload : dhold_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      ihold_q <= '0;
      dhold_q <= '0;
    end else begin
      state_q <= state_d;
      ihold_q <= ihold_d;
      dhold_q <= dhold_d;
    end
  end

endmodule
